// File: rtl/ads8688_pkg.sv
// Shared definitions for the ADS8688 scan scheduler: command words,
// channel-to-command mapping and the scheduler state encoding.
package ads8688_pkg;

  localparam logic [15:0] CMD_NO_OP    = 16'h0000;
  localparam logic [15:0] CMD_MAN_BASE = 16'hC000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // MAN_Ch_n command: channel index lives in bits [12:10]
  function automatic logic [15:0] man_cmd(input logic [2:0] ch);
    return CMD_MAN_BASE | {3'b000, ch, 10'b0};
  endfunction

endpackage

// File: rtl/ads8688_scan_sched_if.sv
// Frame bus between the scan scheduler and the manual-channel SPI controller.
interface ads8688_scan_sched_if;
  // manchn_start is a one-cycle request carrying chsel; chsel holds until the
  // controller answers with a one-cycle manchn_done, ch_data valid with it.
  logic        manchn_start;
  logic [15:0] chsel;
  logic        manchn_done;
  logic [15:0] ch_data;

  modport master (
    output manchn_start,
    output chsel,
    input  manchn_done,
    input  ch_data
  );

  modport slave (
    input  manchn_start,
    input  chsel,
    output manchn_done,
    output ch_data
  );
endinterface

// File: rtl/ads8688_next_ch.sv
// Finds the lowest enabled channel above the current index, or the lowest
// enabled channel overall when 'first' is set.
module ads8688_next_ch #(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     cur,
  input  logic           first,
  output logic [2:0]     nxt,
  output logic           none
);

  // Descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    none = 1'b1;
    nxt  = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (3'(i) > cur))) begin
        none = 1'b0;
        nxt  = 3'(i);
      end
    end
  end

endmodule

// File: rtl/ads8688_scan_sched.sv
// Scan scheduler for the ADS8688: walks the enabled channel mask, issues one
// manual-channel frame per channel plus a trailing NO_OP, realigns the data.
module ads8688_scan_sched
  import ads8688_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 scan_start,
  input  logic                 scan_cont,
  input  logic [NCH-1:0]       ch_en,
  input  logic [15:0]          period,
  ads8688_scan_sched_if.master spi,
  output logic                 scan_busy,
  output logic                 result_valid,
  output logic [2:0]           result_ch,
  output logic [15:0]          result_data,
  output logic                 result_last,
  output logic                 scan_done,
  output logic                 scan_err,
  output state_t               dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [NCH-1:0] mask_q;
  logic [2:0]     cur_ch;
  logic           cur_noop;
  logic [2:0]     prev_ch;
  logic           prev_vld;
  logic [15:0]    gap_cnt;
  logic [TW-1:0]  to_cnt;

  logic           srch_first;
  logic [NCH-1:0] srch_mask;
  logic [2:0]     nx_ch;
  logic           nx_none;

  // A new scan searches the live mask from channel 0; mid-scan uses the latched mask
  assign srch_first = (state == IDLE) || (state == GAP);
  assign srch_mask  = srch_first ? ch_en : mask_q;

  ads8688_next_ch #(.NCH(NCH)) u_next_ch (
    .mask  (srch_mask),
    .cur   (cur_ch),
    .first (srch_first),
    .nxt   (nx_ch),
    .none  (nx_none)
  );

  assign scan_busy = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state            <= IDLE;
      mask_q           <= '0;
      cur_ch           <= 3'd0;
      cur_noop         <= 1'b0;
      prev_ch          <= 3'd0;
      prev_vld         <= 1'b0;
      gap_cnt          <= 16'd0;
      to_cnt           <= '0;
      spi.manchn_start <= 1'b0;
      spi.chsel        <= CMD_NO_OP;
      result_valid     <= 1'b0;
      result_ch        <= 3'd0;
      result_data      <= 16'd0;
      result_last      <= 1'b0;
      scan_done        <= 1'b0;
      scan_err         <= 1'b0;
    end else begin
      spi.manchn_start <= 1'b0;
      result_valid     <= 1'b0;
      result_last      <= 1'b0;
      scan_done        <= 1'b0;
      scan_err         <= 1'b0;

      case (state)
        IDLE: begin
          if (scan_start && !nx_none) begin
            mask_q           <= ch_en;
            state            <= ISSUE;
            spi.manchn_start <= 1'b1;
            spi.chsel        <= man_cmd(nx_ch);
            cur_ch           <= nx_ch;
            cur_noop         <= 1'b0;
            prev_vld         <= 1'b0;
          end
        end

        ISSUE: begin
          state  <= WAIT;
          to_cnt <= TW'(1);
        end

        WAIT: begin
          if (spi.manchn_done) begin
            // Frame k returns the conversion commanded in frame k-1
            if (prev_vld) begin
              result_valid <= 1'b1;
              result_ch    <= prev_ch;
              result_data  <= spi.ch_data;
            end
            if (cur_noop) begin
              result_last <= 1'b1;
              scan_done   <= 1'b1;
              gap_cnt     <= period;
              state       <= scan_cont ? GAP : IDLE;
            end else begin
              prev_ch          <= cur_ch;
              prev_vld         <= 1'b1;
              state            <= ISSUE;
              spi.manchn_start <= 1'b1;
              if (nx_none) begin
                spi.chsel <= CMD_NO_OP;
                cur_noop  <= 1'b1;
              end else begin
                spi.chsel <= man_cmd(nx_ch);
                cur_ch    <= nx_ch;
              end
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            scan_err <= 1'b1;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        GAP: begin
          if (gap_cnt == 16'd0) begin
            if (nx_none) begin
              state <= IDLE;
            end else begin
              mask_q           <= ch_en;
              state            <= ISSUE;
              spi.manchn_start <= 1'b1;
              spi.chsel        <= man_cmd(nx_ch);
              cur_ch           <= nx_ch;
              cur_noop         <= 1'b0;
              prev_vld         <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads8688_scan_sched.sv
// Self-checking bench for ads8688_scan_sched: a randomized SPI controller
// responder plus a mask-level model of the expected frame and result streams.
module tb_ads8688_scan_sched;
  import ads8688_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic        scan_start;
  logic        scan_cont;
  logic [7:0]  ch_en;
  logic [15:0] period;
  logic        scan_busy;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [15:0] result_data;
  logic        result_last;
  logic        scan_done;
  logic        scan_err;
  state_t      dbg_state;

  ads8688_scan_sched_if bus ();

  ads8688_scan_sched #(.NCH(8), .TIMEOUT(1000)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .scan_start   (scan_start),
    .scan_cont    (scan_cont),
    .ch_en        (ch_en),
    .period       (period),
    .spi          (bus),
    .scan_busy    (scan_busy),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .result_last  (result_last),
    .scan_done    (scan_done),
    .scan_err     (scan_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int resp_cnt = 0;
  bit resp_en  = 1'b1;
  bit noise_en = 1'b0;

  logic [15:0] start_q[$];
  int          start_cyc_q[$];
  logic [15:0] sent_q[$];
  int          done_cyc_q[$];
  logic [2:0]  res_ch_q[$];
  logic [15:0] res_data_q[$];
  bit          res_last_q[$];
  int          res_cyc_q[$];
  int          done_cnt, err_cnt, last_done_cyc, last_err_cyc;
  bit          saw_done, saw_err, err_busy, chsel_bad;
  logic [15:0] cur_cmd;

  // scoreboard expectations built by the model
  logic [2:0]  exp_ch_q[$];
  logic [15:0] exp_cmd_q[$];

  function automatic void model_scan(input logic [7:0] mask);
    exp_ch_q.delete();
    exp_cmd_q.delete();
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        exp_ch_q.push_back(3'(c));
        exp_cmd_q.push_back(16'hC000 + 16'(c) * 16'h0400);
      end
    end
    exp_cmd_q.push_back(16'h0000);
  endfunction

  task automatic clear_obs();
    start_q.delete(); start_cyc_q.delete(); sent_q.delete(); done_cyc_q.delete();
    res_ch_q.delete(); res_data_q.delete(); res_last_q.delete(); res_cyc_q.delete();
    done_cnt = 0; err_cnt = 0; last_done_cyc = -1; last_err_cyc = -1;
    err_busy = 1'b0; chsel_bad = 1'b0;
  endtask

  // ---------------- driver: one clock cycle, observe then respond ----------------
  task automatic step();
    logic [15:0] d;
    @(negedge clk);
    cyc++;
    saw_done = 1'b0;
    saw_err  = 1'b0;
    if (resp_cnt > 0 && bus.chsel !== cur_cmd) chsel_bad = 1'b1;
    if (result_valid) begin
      res_ch_q.push_back(result_ch);
      res_data_q.push_back(result_data);
      res_last_q.push_back(result_last);
      res_cyc_q.push_back(cyc);
    end
    if (scan_done) begin done_cnt++; saw_done = 1'b1; last_done_cyc = cyc; end
    if (scan_err) begin err_cnt++; saw_err = 1'b1; last_err_cyc = cyc; err_busy = scan_busy; end
    bus.manchn_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        d = 16'($urandom);
        bus.ch_data = d;
        bus.manchn_done = 1'b1;
        sent_q.push_back(d);
        done_cyc_q.push_back(cyc);
      end
    end else if (!bus.manchn_start && noise_en && $urandom_range(0, 3) == 0) begin
      bus.manchn_done = 1'b1;
      bus.ch_data = 16'($urandom);
    end
    if (bus.manchn_start) begin
      start_q.push_back(bus.chsel);
      start_cyc_q.push_back(cyc);
      cur_cmd = bus.chsel;
      if (resp_en) resp_cnt = $urandom_range(1, 5);
    end
  endtask

  task automatic start_scan(input logic [7:0] mask, output int st_exp);
    st_exp = cyc + 1;
    ch_en = mask;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (saw_done || saw_err) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arstn = 1'b0; scan_start = 1'b0; scan_cont = 1'b0; ch_en = 8'h00; period = 16'd0;
    bus.manchn_done = 1'b0; bus.ch_data = 16'h0000;
    clear_obs();
    repeat (3) step();
    n_tests++;
    if ({scan_busy, result_valid, result_ch, result_data, result_last, scan_done,
         scan_err, bus.manchn_start, bus.chsel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b rv=%b ch=%0d data=%h chsel=%h start=%b exp all zero",
               scan_busy, result_valid, result_ch, result_data, bus.chsel, bus.manchn_start);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    arstn = 1'b1;
    repeat (5) step();
    ch_en = 8'h00; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    repeat (10) step();
    n_tests++;
    if (start_q.size() != 0 || scan_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_start got frames=%0d busy=%b exp frames=0 busy=0",
                         start_q.size(), scan_busy);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] masks[$];
    masks = '{8'h01, 8'hA5, 8'hFF, 8'h80};
    repeat (4) masks.push_back(8'($urandom_range(1, 255)));
    foreach (masks[p]) begin
      int st;
      bit ok;
      int m;
      clear_obs();
      resp_en = 1'b1; noise_en = 1'b1; scan_cont = 1'b0;
      model_scan(masks[p]);
      m = exp_ch_q.size();
      start_scan(masks[p], st);
      wait_end(300, ok);
      repeat (5) step();
      noise_en = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL scan_end mask=%h got none within budget exp scan_done", masks[p]); end
      n_tests++;
      if (start_q.size() != m + 1) begin
        n_fail++; $display("FAIL frame_count mask=%h got=%0d exp=%0d", masks[p], start_q.size(), m + 1);
      end
      n_tests++;
      if (start_cyc_q.size() < 1 || start_cyc_q[0] != st) begin
        n_fail++; $display("FAIL first_start_cycle mask=%h got=%0d exp=%0d", masks[p],
                           (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1, st);
      end
      for (int k = 0; k < start_q.size() && k <= m; k++) begin
        n_tests++;
        if (start_q[k] !== exp_cmd_q[k]) begin
          n_fail++; $display("FAIL chsel mask=%h frame=%0d got=%h exp=%h", masks[p], k + 1, start_q[k], exp_cmd_q[k]);
        end
        if (k > 0 && k <= done_cyc_q.size()) begin
          n_tests++;
          if (start_cyc_q[k] != done_cyc_q[k-1] + 1) begin
            n_fail++; $display("FAIL next_start_cycle mask=%h frame=%0d got=%0d exp=%0d",
                               masks[p], k + 1, start_cyc_q[k], done_cyc_q[k-1] + 1);
          end
        end
      end
      n_tests++;
      if (res_ch_q.size() != m) begin
        n_fail++; $display("FAIL result_count mask=%h got=%0d exp=%0d", masks[p], res_ch_q.size(), m);
      end
      for (int j = 0; j < res_ch_q.size() && j < m && j + 1 < sent_q.size(); j++) begin
        n_tests++;
        if (res_ch_q[j] !== exp_ch_q[j] || res_data_q[j] !== sent_q[j+1] ||
            res_last_q[j] != (j == m - 1) || res_cyc_q[j] != done_cyc_q[j+1] + 1) begin
          n_fail++;
          $display("FAIL result mask=%h idx=%0d got ch=%0d data=%h last=%b cyc=%0d exp ch=%0d data=%h last=%b cyc=%0d",
                   masks[p], j, res_ch_q[j], res_data_q[j], res_last_q[j], res_cyc_q[j],
                   exp_ch_q[j], sent_q[j+1], (j == m - 1), done_cyc_q[j+1] + 1);
        end
      end
      n_tests++;
      if (done_cnt != 1 || err_cnt != 0 || res_cyc_q.size() == 0 || last_done_cyc != res_cyc_q[res_cyc_q.size()-1]) begin
        n_fail++; $display("FAIL scan_done mask=%h got done=%0d err=%0d at=%0d exp one done with last result",
                           masks[p], done_cnt, err_cnt, last_done_cyc);
      end
      n_tests++;
      if (chsel_bad || dbg_state !== IDLE || scan_busy !== 1'b0) begin
        n_fail++; $display("FAIL hold_and_idle mask=%h got chsel_unstable=%b state=%0d busy=%b exp 0,%0d,0",
                           masks[p], chsel_bad, dbg_state, scan_busy, IDLE);
      end
    end
  endtask

  task automatic test_continuous();
    int st;
    bit ok;
    int s;
    logic [2:0]  e_ch[4];
    logic [15:0] e_cmd[6];
    clear_obs();
    resp_en = 1'b1; scan_cont = 1'b1; period = 16'd100;
    start_scan(8'h03, st);
    wait_end(200, ok);
    s = last_done_cyc;
    ch_en = 8'h06;
    repeat (50) step();
    n_tests++;
    if (!ok || scan_busy !== 1'b1 || dbg_state !== GAP) begin
      n_fail++; $display("FAIL gap_busy got ended=%b busy=%b state=%0d exp 1,1,%0d", ok, scan_busy, dbg_state, GAP);
    end
    for (int i = 0; i < 200 && start_q.size() < 4; i++) step();
    scan_cont = 1'b0;
    n_tests++;
    if (start_cyc_q.size() < 4 || start_cyc_q[3] != s + 101) begin
      n_fail++; $display("FAIL period_restart got=%0d exp=%0d",
                         (start_cyc_q.size() > 3) ? start_cyc_q[3] : -1, s + 101);
    end
    wait_end(200, ok);
    repeat (150) step();
    e_cmd = '{16'hC000, 16'hC400, 16'h0000, 16'hC400, 16'hC800, 16'h0000};
    e_ch  = '{3'd0, 3'd1, 3'd1, 3'd2};
    n_tests++;
    if (!ok || done_cnt != 2 || start_q.size() != 6 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL cont_stop got done=%0d frames=%0d state=%0d exp 2,6,%0d",
                         done_cnt, start_q.size(), dbg_state, IDLE);
    end
    for (int k = 0; k < 6 && k < start_q.size(); k++) begin
      n_tests++;
      if (start_q[k] !== e_cmd[k]) begin
        n_fail++; $display("FAIL cont_chsel frame=%0d got=%h exp=%h", k, start_q[k], e_cmd[k]);
      end
    end
    for (int j = 0; j < 4 && j < res_ch_q.size() && sent_q.size() == 6; j++) begin
      n_tests++;
      if (res_ch_q[j] !== e_ch[j] || res_data_q[j] !== sent_q[(j < 2) ? j + 1 : j + 2]) begin
        n_fail++; $display("FAIL cont_result idx=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                           j, res_ch_q[j], res_data_q[j], e_ch[j], sent_q[(j < 2) ? j + 1 : j + 2]);
      end
    end
  endtask

  task automatic test_cont_zero();
    int st;
    bit ok;
    clear_obs();
    scan_cont = 1'b1; period = 16'd5;
    start_scan(8'h01, st);
    wait_end(100, ok);
    ch_en = 8'h00;
    repeat (30) step();
    scan_cont = 1'b0;
    n_tests++;
    if (!ok || start_q.size() != 2 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL cont_zero_mask got frames=%0d state=%0d exp 2,%0d", start_q.size(), dbg_state, IDLE);
    end
  endtask

  task automatic test_timeout();
    int st;
    bit ok;
    clear_obs();
    resp_en = 1'b0;
    start_scan(8'h01, st);
    wait_end(1100, ok);
    repeat (20) step();
    resp_en = 1'b1;
    n_tests++;
    if (!ok || err_cnt != 1 || start_cyc_q.size() == 0 || last_err_cyc != start_cyc_q[0] + 1000) begin
      n_fail++; $display("FAIL timeout_cycle got err=%0d at=%0d exp one at=%0d", err_cnt, last_err_cyc,
                         (start_cyc_q.size() > 0) ? start_cyc_q[0] + 1000 : -1);
    end
    n_tests++;
    if (err_busy !== 1'b0 || done_cnt != 0 || start_q.size() != 1 || res_ch_q.size() != 0) begin
      n_fail++; $display("FAIL timeout_abort got busy=%b done=%0d frames=%0d results=%0d exp 0,0,1,0",
                         err_busy, done_cnt, start_q.size(), res_ch_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int st;
    clear_obs();
    start_scan(8'hFF, st);
    for (int i = 0; i < 40 && !(dbg_state == WAIT && start_q.size() >= 2); i++) step();
    n_tests++;
    if (dbg_state !== WAIT) begin
      n_fail++; $display("FAIL reach_wait got=%0d exp=%0d", dbg_state, WAIT);
    end
    #2;
    arstn = 1'b0;
    #1;
    n_tests++;
    if ({scan_busy, result_valid, result_ch, result_data, result_last, scan_done,
         scan_err, bus.manchn_start, bus.chsel} !== '0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL async_reset got busy=%b chsel=%h state=%0d exp 0,0000,%0d",
                         scan_busy, bus.chsel, dbg_state, IDLE);
    end
    resp_cnt = 0;
    bus.manchn_done = 1'b0;
    clear_obs();
    repeat (3) step();
    arstn = 1'b1;
    repeat (10) step();
    ch_en = 8'h00; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    repeat (30) step();
    n_tests++;
    if (start_q.size() != 0 || scan_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet got frames=%0d busy=%b exp 0,0", start_q.size(), scan_busy);
    end
  endtask

  task automatic test_ignore();
    int st;
    clear_obs();
    scan_cont = 1'b0;
    start_scan(8'h0F, st);
    for (int i = 0; i < 200; i++) begin
      step();
      if (saw_done || saw_err) break;
      ch_en = 8'h80;
      scan_start = 1'($urandom_range(0, 1));
    end
    scan_start = 1'b0;
    repeat (20) step();
    n_tests++;
    if (done_cnt != 1 || start_q.size() != 5 || res_ch_q.size() != 4) begin
      n_fail++; $display("FAIL ignore_counts got done=%0d frames=%0d results=%0d exp 1,5,4",
                         done_cnt, start_q.size(), res_ch_q.size());
    end
    for (int j = 0; j < 4 && j < res_ch_q.size() && j + 1 < sent_q.size(); j++) begin
      n_tests++;
      if (res_ch_q[j] !== 3'(j) || res_data_q[j] !== sent_q[j+1]) begin
        n_fail++; $display("FAIL ignore_result idx=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                           j, res_ch_q[j], res_data_q[j], j, sent_q[j+1]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_patterns();
    test_continuous();
    test_cont_zero();
    test_timeout();
    test_reset_mid();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
